frame_reader: RTL and testbench
===============================

// Module: frame_reader
// PURPOSE
//  Raster-scans the 320x240 RGB image memory and streams its pixels downstream.
//  Sits directly after the image memory. Drives the memory read address and
//  absorbs its 1-cycle registered read latency.
//  Presents pixels on a valid/ready stream with row/frame markers for the
//  display or filter stage that follows.
// PARAMETERS
//  Width      320  pixels per row
//  Height     240  rows per frame
//  ColorBits  8    bits per colour channel
// PORTS
//  clk        in   1          single clock, all logic on posedge
//  rst_n      in   1          synchronous, active-low reset
//  start      in   1          begin one frame scan (sampled only in IDLE)
//  busy       out  1          high from the cycle after start acceptance until done
//  done       out  1          1-cycle pulse, frame fully delivered
//  XRead      out  9          memory read column
//  YRead      out  8          memory read row
//  RRead      in   ColorBits  memory read data R (valid 1 cycle after address)
//  GRead      in   ColorBits  memory read data G
//  BRead      in   ColorBits  memory read data B
//  pix_valid  out  1          stream beat valid
//  pix_ready  in   1          downstream accepts beat
//  pix_r/g/b  out  ColorBits  pixel colour
//  pix_x      out  9          pixel column
//  pix_y      out  8          pixel row
//  pix_sof    out  1          beat is (0,0)
//  pix_eol    out  1          beat has x == Width-1
//  pix_eof    out  1          beat is (Width-1, Height-1)
// BEHAVIOUR
//  - Reset: state IDLE; counters, in-flight flags and FIFO cleared; every output 0.
//  - FSM IDLE -> RUN on start. RUN -> DRAIN after the last address (Width-1,Height-1)
//    is issued. DRAIN -> IDLE after the last beat handshake.
//  - done is high in the first IDLE cycle after DRAIN. busy is high in RUN and DRAIN.
//  - start is ignored outside IDLE. A start in the done cycle is accepted.
//  - Read pipe: an address issued in cycle n has its data on R/G/BRead in cycle n+1.
//    That data is pushed with its x/y into a 4-entry FIFO at the n+2 edge.
//    Two valid bits track the in-flight stages.
//  - Issue rule (RUN only): issue when FIFO occupancy plus in-flight count < 4.
//    The test uses registered values; there is no pop look-ahead.
//    This sustains 1 beat/cycle with pix_ready held high.
//  - Address counter: x increments per issue. At x == Width-1 it wraps to 0 and y
//    increments. XRead/YRead hold their value when not issuing.
//  - Stream output is driven from the FIFO head.
//    - pix_valid = FIFO not empty. Pop on pix_valid & pix_ready.
//    - While pix_valid is high and pix_ready is low, all pix_* fields stay stable.
//  - Latency: start high in cycle 0 -> XRead/YRead = (0,0) in cycle 1 -> pix_valid in cycle 3.
//  - The FIFO never overflows and never duplicates or drops a pixel. Pixels are
//    delivered in strict raster order.
//  - rst_n low mid-frame aborts the scan. The next cycle has pix_valid=0, busy=0
//    and XRead=YRead=0, and no done pulse is generated.
// TESTING
//  Memory model: R=x[7:0], G=y, B=x^y[7:0], 1-cycle read latency.
//  1. start, ready=1 -> beats in cycles 3..76802 with consecutive raster data;
//     done in cycle 76803.
//  2. ready=0 for 10 cycles at beat (100,7) -> beat held stable.
//     At most 4 outstanding reads, then XRead freezes. Resumes with no gap, loss or duplicate.
//  3. Row wrap -> beat (319,0) has eol=1; the next beat is (0,1) with R=0, G=1.
//  4. start pulsed in RUN -> ignored, single frame. start in the done cycle -> new frame,
//     first beat 3 cycles later.
//  5. rst_n=0 one cycle at beat 5000 -> next cycle all outputs 0.
//     A new start restarts at (0,0) with sof=1.
//  6. Width=4, Height=2, random ready -> exactly 8 beats.
//     sof on beat 1, eol on beats 4 and 8, eof on beat 8.

Source files
------------

// File: rtl/frame_reader_if.sv
// Frame reader bus: control, image-memory read port and pixel stream.
// Master side is the frame reader; slave side is memory plus downstream sink.
// Stream uses valid/ready; memory port has a fixed 1-cycle read latency.
interface frame_reader_if #(
  parameter int ColorBits = 8
);
  logic                 start;
  logic                 busy;
  logic                 done;
  logic [8:0]           XRead;
  logic [7:0]           YRead;
  logic [ColorBits-1:0] RRead;
  logic [ColorBits-1:0] GRead;
  logic [ColorBits-1:0] BRead;
  logic                 pix_valid;
  logic                 pix_ready;
  logic [ColorBits-1:0] pix_r;
  logic [ColorBits-1:0] pix_g;
  logic [ColorBits-1:0] pix_b;
  logic [8:0]           pix_x;
  logic [7:0]           pix_y;
  logic                 pix_sof;
  logic                 pix_eol;
  logic                 pix_eof;

  modport master (
    input  start, RRead, GRead, BRead, pix_ready,
    output busy, done, XRead, YRead,
    output pix_valid, pix_r, pix_g, pix_b, pix_x, pix_y, pix_sof, pix_eol, pix_eof
  );

  modport slave (
    output start, RRead, GRead, BRead, pix_ready,
    input  busy, done, XRead, YRead,
    input  pix_valid, pix_r, pix_g, pix_b, pix_x, pix_y, pix_sof, pix_eol, pix_eof
  );
endinterface

// File: rtl/frame_reader.sv
// Raster-scans the image memory and streams pixels with sof/eol/eof markers.
// Latency: start in cycle 0 -> address (0,0) in cycle 1 -> first beat in cycle 3.
// Backpressure: 4-entry FIFO; reads stop when FIFO + in-flight reach 4, fields hold.
module frame_reader #(
  parameter int Width     = 320,
  parameter int Height    = 240,
  parameter int ColorBits = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  frame_reader_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  typedef struct packed {
    logic [ColorBits-1:0] r;
    logic [ColorBits-1:0] g;
    logic [ColorBits-1:0] b;
    logic [8:0]           x;
    logic [7:0]           y;
  } pix_t;

  localparam logic [8:0] XLast = 9'(Width - 1);
  localparam logic [7:0] YLast = 8'(Height - 1);

  state_t     r_state, w_state_nxt;
  logic       r_va;            // address on XRead/YRead is a live read this cycle
  logic       r_vb;            // memory data on R/G/BRead is live this cycle
  logic       r_done;
  logic [8:0] r_xrd, r_xb, w_xnxt;
  logic [7:0] r_yrd, r_yb, w_ynxt;
  pix_t       r_fifo [4];
  logic [1:0] r_wp, r_rp;
  logic [2:0] r_cnt, w_occ;
  logic       w_issue, w_push, w_pop, w_vld, w_last_addr, w_last_beat;
  pix_t       w_head, w_in;

  // Occupancy seen by the issue rule: FIFO entries plus both in-flight stages.
  assign w_occ       = r_cnt + {2'b00, r_va} + {2'b00, r_vb};
  assign w_last_addr = r_va && (r_xrd == XLast) && (r_yrd == YLast);
  assign w_vld       = (r_cnt != 3'd0);
  assign w_head      = r_fifo[r_rp];
  assign w_last_beat = (w_head.x == XLast) && (w_head.y == YLast);
  assign w_push      = r_vb;
  assign w_pop       = w_vld && bus.pix_ready;
  assign w_in        = '{r: bus.RRead, g: bus.GRead, b: bus.BRead, x: r_xb, y: r_yb};

  // Next read address: a new frame starts at (0,0), otherwise raster increment.
  always_comb begin
    w_xnxt = 9'd0;
    w_ynxt = 8'd0;
    if (r_state != S_IDLE) begin
      if (r_xrd == XLast) begin
        w_xnxt = 9'd0;
        w_ynxt = r_yrd + 8'd1;
      end else begin
        w_xnxt = r_xrd + 9'd1;
        w_ynxt = r_yrd;
      end
    end
  end

  // FSM next state and read-issue decision from registered occupancy only.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_issue     = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last_addr) begin
          w_state_nxt = S_DRAIN;
        end else if (w_occ < 3'd4) begin
          w_issue = 1'b1;
        end
      end
      S_DRAIN: begin
        if (w_pop && w_last_beat) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, read pipeline, address counter and FIFO pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_va    <= 1'b0;
      r_vb    <= 1'b0;
      r_done  <= 1'b0;
      r_xrd   <= 9'd0;
      r_yrd   <= 8'd0;
      r_xb    <= 9'd0;
      r_yb    <= 8'd0;
      r_wp    <= 2'd0;
      r_rp    <= 2'd0;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_va    <= w_issue;
      r_vb    <= r_va;
      r_done  <= (r_state == S_DRAIN) && w_pop && w_last_beat;
      if (w_issue) begin
        r_xrd <= w_xnxt;
        r_yrd <= w_ynxt;
      end
      if (r_va) begin
        r_xb <= r_xrd;
        r_yb <= r_yrd;
      end
      if (w_push) r_wp <= r_wp + 2'd1;
      if (w_pop)  r_rp <= r_rp + 2'd1;
      r_cnt <= r_cnt + {2'b00, w_push} - {2'b00, w_pop};
    end
  end

  // FIFO storage; contents need no reset because the outputs are gated by valid.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wp] <= w_in;
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = r_done;
  assign bus.XRead     = r_xrd;
  assign bus.YRead     = r_yrd;
  assign bus.pix_valid = w_vld;
  assign bus.pix_r     = w_vld ? w_head.r : '0;
  assign bus.pix_g     = w_vld ? w_head.g : '0;
  assign bus.pix_b     = w_vld ? w_head.b : '0;
  assign bus.pix_x     = w_vld ? w_head.x : 9'd0;
  assign bus.pix_y     = w_vld ? w_head.y : 8'd0;
  assign bus.pix_sof   = w_vld && (w_head.x == 9'd0) && (w_head.y == 8'd0);
  assign bus.pix_eol   = w_vld && (w_head.x == XLast);
  assign bus.pix_eof   = w_vld && w_last_beat;

endmodule

// File: tb/tb_frame_reader.sv
// Bench for frame_reader: full 320x240 frame, stall, restart, abort, and a 4x2 frame.
module tb_frame_reader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  frame_reader_if #(.ColorBits(8)) bus ();
  frame_reader_if #(.ColorBits(8)) s_bus ();

  frame_reader #(.Width(320), .Height(240), .ColorBits(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master));
  frame_reader #(.Width(4), .Height(2), .ColorBits(8)) u_small (
    .clk(clk), .rst_n(rst_n), .bus(s_bus.master));

  // Image memory model: R=x, G=y, B=x^y with one cycle of read latency.
  always @(posedge clk) begin
    bus.RRead   <= bus.XRead[7:0];
    bus.GRead   <= bus.YRead;
    bus.BRead   <= bus.XRead[7:0] ^ bus.YRead;
    s_bus.RRead <= s_bus.XRead[7:0];
    s_bus.GRead <= s_bus.YRead;
    s_bus.BRead <= s_bus.XRead[7:0] ^ s_bus.YRead;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Stream monitor for the full-size instance: raster order, stability, done count.
  int beats = 0, raster_bad = 0, stable_bad = 0, stall_seen = 0, done_cnt = 0;
  int exp_idx = 0;
  logic prev_stall = 1'b0;
  logic [31:0] prev_fields;
  always begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      exp_idx    = 0;
      prev_stall = 1'b0;
    end else begin
      if (bus.done) done_cnt++;
      if (prev_stall && (!bus.pix_valid ||
          prev_fields != {bus.pix_x, bus.pix_y, bus.pix_r, bus.pix_sof, bus.pix_eol, bus.pix_eof, 4'd0}))
        stable_bad++;
      if (bus.pix_valid && !bus.pix_ready) stall_seen++;
      if (bus.pix_valid && bus.pix_ready) begin
        int ex, ey;
        ex = exp_idx % 320;
        ey = exp_idx / 320;
        if (bus.pix_x != 9'(ex) || bus.pix_y != 8'(ey) || bus.pix_r != 8'(ex & 255) ||
            bus.pix_g != 8'(ey) || bus.pix_b != 8'((ex ^ ey) & 255) ||
            bus.pix_sof != (exp_idx == 0) || bus.pix_eol != (ex == 319) ||
            bus.pix_eof != (exp_idx == 76799)) begin
          if (raster_bad == 0)
            $display("first bad beat: index %0d got x=%0d y=%0d", exp_idx, bus.pix_x, bus.pix_y);
          raster_bad++;
        end
        beats++;
        exp_idx = (exp_idx == 76799) ? 0 : exp_idx + 1;
      end
      prev_stall  = bus.pix_valid && !bus.pix_ready;
      prev_fields = {bus.pix_x, bus.pix_y, bus.pix_r, bus.pix_sof, bus.pix_eol, bus.pix_eof, 4'd0};
    end
  end

  typedef struct {
    int   cyc;
    logic vld;
    int   px, py;
    logic sof, eol, eof;
    int   r, g, b;
    logic busy, done;
    int   xr, yr;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  initial begin
    int c;
    int found, gaps;
    int sb, sdone, sbad, sunst;
    logic [7:0] sof_m, eol_m, eof_m;
    logic sprev;
    logic [16:0] sprevf;

    //            cyc    vld px  py  sof eol eof r   g    b    busy done xr   yr
    vecs[0] = '{0,     0, 0,   0,   0, 0, 0, 0,  0,   0,   0, 0, 0,   0};
    vecs[1] = '{1,     0, 0,   0,   0, 0, 0, 0,  0,   0,   1, 0, 0,   0};
    vecs[2] = '{2,     0, 0,   0,   0, 0, 0, 0,  0,   0,   1, 0, 1,   0};
    vecs[3] = '{3,     1, 0,   0,   1, 0, 0, 0,  0,   0,   1, 0, 2,   0};
    vecs[4] = '{4,     1, 1,   0,   0, 0, 0, 1,  0,   1,   1, 0, 3,   0};
    vecs[5] = '{322,   1, 319, 0,   0, 1, 0, 63, 0,   63,  1, 0, 1,   1};
    vecs[6] = '{323,   1, 0,   1,   0, 0, 0, 0,  1,   1,   1, 0, 2,   1};
    vecs[7] = '{2343,  1, 100, 7,   0, 0, 0, 100, 7,  99,  1, 0, 102, 7};
    vecs[8] = '{76802, 1, 319, 239, 0, 1, 1, 63, 239, 208, 1, 0, 319, 239};
    vecs[9] = '{76803, 0, 0,   0,   0, 0, 0, 0,  0,   0,   0, 1, 319, 239};

    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.pix_ready = 1'b1;
    s_bus.start = 1'b0;
    s_bus.pix_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset valid", bus.pix_valid, 0);
    check("reset XRead", bus.XRead, 0);
    check("reset YRead", bus.YRead, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Full frame with ready held high, checked at table checkpoints.
    bus.start = 1'b1;
    c = 0;
    for (int i = 0; i < NV; i++) begin
      while (c < vecs[i].cyc) begin
        @(negedge clk);
        c++;
        bus.start = 1'b0;
      end
      #1;
      check($sformatf("v%0d valid", i), bus.pix_valid, vecs[i].vld);
      check($sformatf("v%0d x", i), bus.pix_x, vecs[i].px);
      check($sformatf("v%0d y", i), bus.pix_y, vecs[i].py);
      check($sformatf("v%0d sof", i), bus.pix_sof, vecs[i].sof);
      check($sformatf("v%0d eol", i), bus.pix_eol, vecs[i].eol);
      check($sformatf("v%0d eof", i), bus.pix_eof, vecs[i].eof);
      check($sformatf("v%0d r", i), bus.pix_r, vecs[i].r);
      check($sformatf("v%0d g", i), bus.pix_g, vecs[i].g);
      check($sformatf("v%0d b", i), bus.pix_b, vecs[i].b);
      check($sformatf("v%0d busy", i), bus.busy, vecs[i].busy);
      check($sformatf("v%0d done", i), bus.done, vecs[i].done);
      check($sformatf("v%0d XRead", i), bus.XRead, vecs[i].xr);
      check($sformatf("v%0d YRead", i), bus.YRead, vecs[i].yr);
    end

    // Start in the done cycle: new frame, first beat three cycles later.
    bus.start = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      check($sformatf("restart c%0d valid", k), bus.pix_valid, (k == 3));
    end
    check("restart sof", bus.pix_sof, 1);
    check("restart x", bus.pix_x, 0);

    // Stall at beat (100,7) for 10 cycles, with a stray start pulse while running.
    found = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (bus.pix_valid && bus.pix_x == 9'd100 && bus.pix_y == 8'd7) begin
        found = 1;
        break;
      end
    end
    check("stall beat found", found, 1);
    bus.pix_ready = 1'b0;
    bus.start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    #1;
    check("stall held x", bus.pix_x, 100);
    check("stall held y", bus.pix_y, 7);
    check("stall held valid", bus.pix_valid, 1);
    check("stall XRead frozen", bus.XRead, 103);
    check("stall YRead frozen", bus.YRead, 7);
    check("stall busy", bus.busy, 1);
    bus.pix_ready = 1'b1;
    gaps = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      #1;
      if (!bus.pix_valid || bus.pix_x != 9'(100 + i)) gaps++;
    end
    check("resume gaps", gaps, 0);

    // Reset pulse at beat 5000 = (200,15) aborts the frame.
    found = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (bus.pix_valid && bus.pix_x == 9'd200 && bus.pix_y == 8'd15) begin
        found = 1;
        break;
      end
    end
    check("beat 5000 found", found, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort valid", bus.pix_valid, 0);
    check("abort busy", bus.busy, 0);
    check("abort done", bus.done, 0);
    check("abort XRead", bus.XRead, 0);
    check("abort YRead", bus.YRead, 0);
    check("abort pix fields", {bus.pix_x, bus.pix_y, bus.pix_r, bus.pix_g, bus.pix_b}, 0);
    check("abort markers", {bus.pix_sof, bus.pix_eol, bus.pix_eof}, 0);
    @(negedge clk);
    #1;
    check("abort no done", bus.done, 0);
    check("abort stays idle", bus.busy, 0);

    // Fresh start after abort restarts at (0,0); cut short by another reset.
    bus.start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      if (k == 1) check("after abort XRead", bus.XRead, 0);
      if (k == 3) begin
        check("after abort valid", bus.pix_valid, 1);
        check("after abort sof", bus.pix_sof, 1);
        check("after abort xy", {bus.pix_x, bus.pix_y}, 0);
      end
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #3;
    check("total beats", beats, 76800 + 5000 + 7);
    check("raster errors", raster_bad, 0);
    check("stall stability", stable_bad, 0);
    check("stall cycles", stall_seen, 10);
    check("done pulses", done_cnt, 1);

    // 4x2 instance with random ready.
    sb = 0; sdone = 0; sbad = 0; sunst = 0;
    sof_m = '0; eol_m = '0; eof_m = '0;
    sprev = 1'b0;
    sprevf = '0;
    @(negedge clk);
    s_bus.start = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      s_bus.start = 1'b0;
      s_bus.pix_ready = 1'($urandom_range(0, 1));
      #2;
      if (sprev && (!s_bus.pix_valid || sprevf != {s_bus.pix_x, s_bus.pix_y})) sunst++;
      if (s_bus.pix_valid && s_bus.pix_ready) begin
        if (sb < 8) begin
          if (s_bus.pix_x != 9'(sb % 4) || s_bus.pix_y != 8'(sb / 4) ||
              s_bus.pix_r != 8'(sb % 4) || s_bus.pix_g != 8'(sb / 4) ||
              s_bus.pix_b != 8'((sb % 4) ^ (sb / 4)))
            sbad++;
          sof_m[sb] = s_bus.pix_sof;
          eol_m[sb] = s_bus.pix_eol;
          eof_m[sb] = s_bus.pix_eof;
        end
        sb++;
      end
      sprev  = s_bus.pix_valid && !s_bus.pix_ready;
      sprevf = {s_bus.pix_x, s_bus.pix_y};
      if (s_bus.done) begin
        sdone = 1;
        break;
      end
    end
    check("small done seen", sdone, 1);
    check("small beats", sb, 8);
    check("small sof beats", sof_m, 8'h01);
    check("small eol beats", eol_m, 8'h88);
    check("small eof beats", eof_m, 8'h80);
    check("small data", sbad, 0);
    check("small stability", sunst, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
